// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: two-stage pipelined carry-lookahead adder with a valid/ready handshake.
// Stage 1 registers bit and group generate/propagate terms. Stage 2 resolves the
// group carries with a second-level lookahead and registers the result.
// Optional feature: define CLA_OVF_EN to add the registered two's-complement
// overflow output ovf_out.
module pipe_cla_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             c_out
`ifdef CLA_OVF_EN
   ,
   output logic             ovf_out
`endif
);

   localparam int unsigned NGRP = WIDTH / GROUP;

   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;
   logic [NGRP-1:0]  w_grp_g;
   logic [NGRP-1:0]  w_grp_p;
   logic [NGRP:0]    w_grp_c;
   logic [WIDTH-1:0] w_c;
   logic [WIDTH-1:0] w_sum;
   logic             w_s1_adv;
   logic             w_s2_adv;

   logic             r_s1_valid;
   logic [NGRP-1:0]  r_s1_grp_g;
   logic [NGRP-1:0]  r_s1_grp_p;
   logic [WIDTH-1:0] r_s1_g;
   logic [WIDTH-1:0] r_s1_p;
   logic             r_s1_cin;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
`ifdef CLA_OVF_EN
   logic             r_ovf;
`endif

   // Bit-level generate / propagate.
   assign w_g = a_in & b_in;
   assign w_p = a_in ^ b_in;

   // Handshake: a stage moves when it is empty or its successor moves.
   assign w_s2_adv  = !r_s2_valid || out_ready;
   assign w_s1_adv  = !r_s1_valid || w_s2_adv;
   assign in_ready  = !r_s1_valid || w_s1_adv;
   assign out_valid = r_s2_valid;
   assign sum_out   = r_sum;
   assign c_out     = r_cout;
`ifdef CLA_OVF_EN
   assign ovf_out   = r_ovf;
`endif

   // First-level lookahead: group generate/propagate for each GROUP-bit slice.
   always_comb begin : grp_pg
      logic v_g;
      logic v_p;
      v_g     = 1'b0;
      v_p     = 1'b0;
      w_grp_g = '0;
      w_grp_p = '0;
      for (int k = 0; k < int'(NGRP); k++) begin
         v_g = 1'b0;
         v_p = 1'b1;
         for (int i = 0; i < int'(GROUP); i++) begin
            v_g = w_g[k*GROUP+i] | (w_p[k*GROUP+i] & v_g);
            v_p = v_p & w_p[k*GROUP+i];
         end
         w_grp_g[k] = v_g;
         w_grp_p[k] = v_p;
      end
   end

   // Stage 1 registers: valid flag plus PG terms, loaded only with a valid beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_grp_g <= '0;
         r_s1_grp_p <= '0;
         r_s1_g     <= '0;
         r_s1_p     <= '0;
         r_s1_cin   <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_grp_g <= w_grp_g;
            r_s1_grp_p <= w_grp_p;
            r_s1_g     <= w_g;
            r_s1_p     <= w_p;
            r_s1_cin   <= c_in;
         end
      end
   end

   // Second-level lookahead: carry into each group as a flat sum of products.
   always_comb begin : grp_carry
      logic v_c;
      logic v_t;
      v_c     = 1'b0;
      v_t     = 1'b0;
      w_grp_c = '0;
      for (int k = 0; k <= int'(NGRP); k++) begin
         v_t = r_s1_cin;
         for (int m = 0; m < k; m++) v_t = v_t & r_s1_grp_p[m];
         v_c = v_t;
         for (int j = 0; j < k; j++) begin
            v_t = r_s1_grp_g[j];
            for (int m = j + 1; m < k; m++) v_t = v_t & r_s1_grp_p[m];
            v_c = v_c | v_t;
         end
         w_grp_c[k] = v_c;
      end
   end

   // Carry into every bit, seeded from its group carry.
   always_comb begin : bit_carry
      logic v_c;
      v_c = 1'b0;
      w_c = '0;
      for (int k = 0; k < int'(NGRP); k++) begin
         v_c = w_grp_c[k];
         for (int i = 0; i < int'(GROUP); i++) begin
            w_c[k*GROUP+i] = v_c;
            v_c = r_s1_g[k*GROUP+i] | (r_s1_p[k*GROUP+i] & v_c);
         end
      end
   end

   assign w_sum = r_s1_p ^ w_c;

   // Stage 2 / output registers: hold under back-pressure, load only on valid beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_sum      <= '0;
         r_cout     <= 1'b0;
`ifdef CLA_OVF_EN
         r_ovf      <= 1'b0;
`endif
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_grp_c[NGRP];
`ifdef CLA_OVF_EN
            r_ovf  <= w_c[WIDTH-1] ^ w_grp_c[NGRP];
`endif
         end
      end
   end

endmodule
